// File: rtl/game_collision_scheduler.sv
// Pairwise target-collision checker: one shared rectangle comparator walks every i<j pair
// of a per-frame snapshot, one pair per clock, with per-pair immunity counted in frames.
module game_collision_scheduler #(
  parameter int N_TARGETS       = 4,
  parameter int w_x             = $clog2(640),
  parameter int w_y             = $clog2(480),
  parameter int IMMUNITY_FRAMES = 5
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [N_TARGETS-1:0]            enable_targets,
  input  logic [N_TARGETS-1:0][w_x-1:0]   sprite_left,
  input  logic [N_TARGETS-1:0][w_x-1:0]   sprite_right,
  input  logic [N_TARGETS-1:0][w_y-1:0]   sprite_top,
  input  logic [N_TARGETS-1:0][w_y-1:0]   sprite_bottom,
  output logic                            busy,
  output logic                            done,
  output logic [N_TARGETS-1:0]            collide_x,
  output logic [N_TARGETS-1:0]            collide_y,
  output logic                            overrun
);

  localparam int P  = N_TARGETS * (N_TARGETS - 1) / 2;
  localparam int IW = $clog2(N_TARGETS);
  localparam int PW = (P > 1) ? $clog2(P) : 1;
  localparam int CW = (IMMUNITY_FRAMES > 0) ? $clog2(IMMUNITY_FRAMES + 1) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, FINISH} state_t;

  state_t                          state_q, state_d;
  logic [IW-1:0]                   i_q, j_q;
  logic [PW-1:0]                   p_q;
  logic [N_TARGETS-1:0]            en_q;
  logic [N_TARGETS-1:0][w_x-1:0]   left_q, right_q;
  logic [N_TARGETS-1:0][w_y-1:0]   top_q, bottom_q;
  logic [N_TARGETS-1:0]            acc_q;
  logic [CW-1:0]                   imm_q [P];
  logic [P-1:0]                    loaded_q;
  logic                            busy_q, done_q, overrun_q;
  logic [N_TARGETS-1:0]            collide_q;

  logic pair_en, overlap, hit, last_pair;

  assign pair_en   = en_q[i_q] & en_q[j_q];
  assign overlap   = (left_q[i_q] < right_q[j_q]) && (right_q[i_q] > left_q[j_q]) &&
                     (top_q[i_q] < bottom_q[j_q]) && (bottom_q[i_q] > top_q[j_q]);
  assign hit       = pair_en && overlap && (imm_q[p_q] == '0);
  assign last_pair = (p_q == PW'(P - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SCAN;
      SCAN:    if (last_pair) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      i_q       <= '0;
      j_q       <= '0;
      p_q       <= '0;
      en_q      <= '0;
      left_q    <= '0;
      right_q   <= '0;
      top_q     <= '0;
      bottom_q  <= '0;
      acc_q     <= '0;
      loaded_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      collide_q <= '0;
      for (int k = 0; k < P; k++) imm_q[k] <= '0;
    end else begin
      done_q    <= 1'b0;
      overrun_q <= start && (state_q != IDLE);
      unique case (state_q)
        IDLE: begin
          if (start) begin
            en_q     <= enable_targets;
            left_q   <= sprite_left;
            right_q  <= sprite_right;
            top_q    <= sprite_top;
            bottom_q <= sprite_bottom;
            i_q      <= '0;
            j_q      <= IW'(1);
            p_q      <= '0;
            acc_q    <= '0;
            loaded_q <= '0;
            busy_q   <= 1'b1;
          end
        end
        SCAN: begin
          // A disabled partner forgets any pending immunity for the pair.
          if (!pair_en) begin
            imm_q[p_q] <= '0;
          end else if (hit) begin
            acc_q[i_q]    <= 1'b1;
            acc_q[j_q]    <= 1'b1;
            imm_q[p_q]    <= CW'(IMMUNITY_FRAMES);
            loaded_q[p_q] <= 1'b1;
          end
          if (j_q == IW'(N_TARGETS - 1)) begin
            i_q <= i_q + IW'(1);
            j_q <= i_q + IW'(2);
          end else begin
            j_q <= j_q + IW'(1);
          end
          p_q <= p_q + PW'(1);
        end
        FINISH: begin
          collide_q <= acc_q;
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
          for (int k = 0; k < P; k++) begin
            if (!loaded_q[k] && (imm_q[k] != '0)) imm_q[k] <= imm_q[k] - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign overrun   = overrun_q;
  assign collide_x = collide_q;
  assign collide_y = collide_q;

endmodule

// File: tb/tb_game_collision_scheduler.sv
// Self-checking bench for game_collision_scheduler (4 targets, 2-frame immunity);
// the reference model tracks the frame of each pair's last hit rather than countdowns.
module tb_game_collision_scheduler;

  localparam int N   = 4;
  localparam int WX  = 10;
  localparam int WY  = 9;
  localparam int IMM = 2;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   start = 1'b0;
  logic [N-1:0]           enable_targets = '0;
  logic [N-1:0][WX-1:0]   sprite_left = '0, sprite_right = '0;
  logic [N-1:0][WY-1:0]   sprite_top = '0, sprite_bottom = '0;
  logic                   busy, done, overrun;
  logic [N-1:0]           collide_x, collide_y;

  int checks = 0;
  int errors = 0;

  int l [N], r [N], t [N], b [N];
  bit en [N];
  bit lh_valid [N][N];
  int last_hit [N][N];
  int frame_no = 0;

  always #5 clk = ~clk;

  game_collision_scheduler #(
    .N_TARGETS(N), .w_x(WX), .w_y(WY), .IMMUNITY_FRAMES(IMM)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .enable_targets(enable_targets),
    .sprite_left(sprite_left), .sprite_right(sprite_right),
    .sprite_top(sprite_top), .sprite_bottom(sprite_bottom),
    .busy(busy), .done(done), .collide_x(collide_x), .collide_y(collide_y),
    .overrun(overrun)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      enable_targets[i] = en[i];
      sprite_left[i]    = WX'(l[i]);
      sprite_right[i]   = WX'(r[i]);
      sprite_top[i]     = WY'(t[i]);
      sprite_bottom[i]  = WY'(b[i]);
    end
  endtask

  function automatic void set_rect(int k, int x0, int x1, int y0, int y1);
    l[k] = x0; r[k] = x1; t[k] = y0; b[k] = y1; en[k] = 1'b1;
  endfunction

  task automatic default_scene();
    set_rect(0, 10, 30, 10, 30);
    set_rect(1, 20, 40, 20, 40);
    set_rect(2, 200, 220, 200, 220);
    set_rect(3, 400, 420, 300, 320);
    drive_inputs();
  endtask

  function automatic bit overlaps(int i, int j);
    return (l[i] < r[j]) && (r[i] > l[j]) && (t[i] < b[j]) && (b[i] > t[j]);
  endfunction

  // One frame of the rules: a pair hits if both enabled, overlapping, and its last hit
  // is more than IMM frames ago; disabling either target forgets the last hit.
  function automatic logic [N-1:0] model_frame();
    logic [N-1:0] exp_v;
    exp_v = '0;
    frame_no++;
    for (int i = 0; i < N; i++) begin
      for (int j = i + 1; j < N; j++) begin
        if (!(en[i] && en[j])) begin
          lh_valid[i][j] = 1'b0;
        end else if (overlaps(i, j) &&
                     (!lh_valid[i][j] || (frame_no - last_hit[i][j] > IMM))) begin
          exp_v[i] = 1'b1;
          exp_v[j] = 1'b1;
          lh_valid[i][j] = 1'b1;
          last_hit[i][j] = frame_no;
        end
      end
    end
    return exp_v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) lh_valid[i][j] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    model_reset();
  endtask

  // Pulses start and returns the edge count from the start edge to done (-1 on timeout).
  task automatic run_frame(output int lat);
    lat = -1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < N; i++) begin
        sprite_left[i]   = WX'($urandom);
        sprite_right[i]  = WX'($urandom);
        sprite_top[i]    = WY'($urandom);
        sprite_bottom[i] = WY'($urandom);
      end
      enable_targets = N'($urandom);
      start = 1'($urandom);
      tick();
    end
    start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    checks++; if (collide_x !== 4'b0000) begin errors++; $display("FAIL reset_collide_x: got %b expected 0000", collide_x); end
    checks++; if (collide_y !== 4'b0000) begin errors++; $display("FAIL reset_collide_y: got %b expected 0000", collide_y); end
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_basic_hit();
    logic [N-1:0] keep;
    do_reset();
    default_scene();
    void'(model_frame());
    start = 1'b1;
    tick();
    start = 1'b0;
    // Moving t1 away after the snapshot edge must not change this frame's result.
    set_rect(1, 500, 520, 400, 420);
    drive_inputs();
    for (int k = 1; k <= 7; k++) begin
      tick();
      checks++;
      if (busy !== (k <= 6)) begin errors++; $display("FAIL basic_busy_edge%0d: got %b expected %b", k, busy, (k <= 6)); end
      checks++;
      if (done !== (k == 7)) begin errors++; $display("FAIL basic_done_edge%0d: got %b expected %b", k, done, (k == 7)); end
    end
    checks++; if (collide_x !== 4'b0011) begin errors++; $display("FAIL basic_collide_x: got %b expected 0011", collide_x); end
    checks++; if (collide_y !== 4'b0011) begin errors++; $display("FAIL basic_collide_y: got %b expected 0011", collide_y); end
    keep = collide_x;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b expected 0", done); end
    end
    checks++; if (collide_x !== 4'b0011) begin errors++; $display("FAIL basic_hold: got %b expected 0011 (was %b)", collide_x, keep); end
  endtask

  task automatic test_touching();
    logic [N-1:0] want [3];
    int lat;
    want[0] = 4'b0000; want[1] = 4'b0000; want[2] = 4'b0011;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      default_scene();
      case (c)
        0: set_rect(1, 30, 50, 15, 35);
        1: set_rect(1, 15, 35, 30, 50);
        default: set_rect(1, 29, 49, 29, 49);
      endcase
      drive_inputs();
      void'(model_frame());
      run_frame(lat);
      checks++; if (lat != 7) begin errors++; $display("FAIL touch%0d_latency: got %0d expected 7", c, lat); end
      checks++; if (collide_x !== want[c]) begin errors++; $display("FAIL touch%0d_collide_x: got %b expected %b", c, collide_x, want[c]); end
    end
  endtask

  task automatic test_immunity();
    bit pat [5];
    int lat;
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1; pat[4] = 0;
    do_reset();
    default_scene();
    for (int f = 0; f < 5; f++) begin
      void'(model_frame());
      run_frame(lat);
      checks++; if (lat != 7) begin errors++; $display("FAIL imm_f%0d_latency: got %0d expected 7", f + 1, lat); end
      checks++;
      if (collide_x !== {2'b00, pat[f], pat[f]}) begin
        errors++;
        $display("FAIL imm_f%0d_collide_x: got %b expected %b", f + 1, collide_x, {2'b00, pat[f], pat[f]});
      end
    end
  endtask

  task automatic test_disable_clears();
    logic [N-1:0] want [3];
    int lat;
    want[0] = 4'b0011; want[1] = 4'b0000; want[2] = 4'b0011;
    do_reset();
    default_scene();
    for (int f = 0; f < 3; f++) begin
      en[1] = (f != 1);
      drive_inputs();
      void'(model_frame());
      run_frame(lat);
      checks++; if (lat != 7) begin errors++; $display("FAIL dis_f%0d_latency: got %0d expected 7", f + 1, lat); end
      checks++; if (collide_x !== want[f]) begin errors++; $display("FAIL dis_f%0d_collide_x: got %b expected %b", f + 1, collide_x, want[f]); end
    end
  endtask

  task automatic test_overrun();
    int ndone;
    do_reset();
    default_scene();
    void'(model_frame());
    ndone = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (k == 3) start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (overrun !== (k == 3)) begin errors++; $display("FAIL overrun_edge%0d: got %b expected %b", k, overrun, (k == 3)); end
      if (done) begin
        ndone++;
        checks++;
        if (k != 7) begin errors++; $display("FAIL overrun_done_edge: got %0d expected 7", k); end
      end
    end
    checks++; if (ndone != 1) begin errors++; $display("FAIL overrun_done_count: got %0d expected 1", ndone); end
    checks++; if (collide_x !== 4'b0011) begin errors++; $display("FAIL overrun_collide_x: got %b expected 0011", collide_x); end
  endtask

  task automatic test_midscan_reset();
    int lat;
    int ndone;
    do_reset();
    default_scene();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 3; k++) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    model_reset();
    ndone = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (done) ndone++;
    end
    checks++; if (ndone != 0) begin errors++; $display("FAIL midrst_done_count: got %0d expected 0", ndone); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    checks++; if (collide_x !== 4'b0000) begin errors++; $display("FAIL midrst_collide_x: got %b expected 0000", collide_x); end
    void'(model_frame());
    run_frame(lat);
    checks++; if (lat != 7) begin errors++; $display("FAIL midrst_latency: got %0d expected 7", lat); end
    checks++; if (collide_x !== 4'b0011) begin errors++; $display("FAIL midrst_collide_x_after: got %b expected 0011", collide_x); end
  endtask

  task automatic test_random();
    logic [N-1:0] exp_v;
    int lat;
    do_reset();
    for (int f = 0; f < 60; f++) begin
      if (f == 0 || ($urandom % 3) != 0) begin
        for (int i = 0; i < N; i++) begin
          l[i] = $urandom_range(0, 120);
          r[i] = l[i] + $urandom_range(0, 50);
          t[i] = $urandom_range(0, 120);
          b[i] = t[i] + $urandom_range(0, 50);
          en[i] = (($urandom % 5) != 0);
        end
      end
      drive_inputs();
      exp_v = model_frame();
      run_frame(lat);
      $display("frame %0d: latency=%0d collide_x=%b collide_y=%b model=%b", f, lat, collide_x, collide_y, exp_v);
      checks++; if (lat != 7) begin errors++; $display("FAIL rand%0d_latency: got %0d expected 7", f, lat); end
      checks++; if (collide_x !== exp_v) begin errors++; $display("FAIL rand%0d_collide_x: got %b expected %b", f, collide_x, exp_v); end
      checks++; if (collide_y !== exp_v) begin errors++; $display("FAIL rand%0d_collide_y: got %b expected %b", f, collide_y, exp_v); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_hit();
    test_touching();
    test_immunity();
    test_disable_clears();
    test_overrun();
    test_midscan_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
